mole_spawner: RTL



---
 rtl/mole_spawner_if.sv | 21 ++
 rtl/mole_spawner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mole_spawner_if.sv
// Spawner <-> timer-array bundle: game controls and hole status in, spawn requests out.
interface mole_spawner_if;
    logic       enable;
    logic [1:0] difficulty;
    logic [7:0] omole;
    logic [7:0] mole;
    logic [2:0] moletime;
    logic [7:0] spawn_count;

    // master: the spawner itself
    modport master (
        input  enable, difficulty, omole,
        output mole, moletime, spawn_count
    );

    // slave: game controller / timer array side
    modport slave (
        output enable, difficulty, omole,
        input  mole, moletime, spawn_count
    );
endinterface

// File: rtl/mole_spawner.sv
// Decides when and into which free hole a new mole is launched; one-cycle one-hot
// spawn pulse plus duration code, paced by a difficulty-selected interval.
module mole_spawner #(
    parameter int          TICK_DIV   = 100000,
    parameter int          SPAWN_EASY = 1500,
    parameter int          SPAWN_MED  = 1000,
    parameter int          SPAWN_HARD = 600,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic           CLK100MHZ,
    input  logic           reset,
    mole_spawner_if.master bus
);

    localparam int SPAWN_MAX_AB = (SPAWN_EASY > SPAWN_MED) ? SPAWN_EASY : SPAWN_MED;
    localparam int SPAWN_MAX    = (SPAWN_MAX_AB > SPAWN_HARD) ? SPAWN_MAX_AB : SPAWN_HARD;
    localparam int PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW           = $clog2(SPAWN_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PICK,
        FIRE
    } state_t;

    state_t          state_reg, state_next;
    logic [15:0]     lfsr_reg, lfsr_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [IW-1:0]   interval_reg, interval_next;
    logic [2:0]      cand_reg, cand_next;
    logic [2:0]      probe_reg, probe_next;
    logic [7:0]      mole_reg, mole_next;
    logic [2:0]      moletime_reg, moletime_next;
    logic [7:0]      count_reg, count_next;

    logic [IW-1:0]   reload_val;
    logic [2:0]      cand_eff;
    logic            hole_busy;
    logic            tick_wrap;
    logic [7:0]      fire_onehot;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    always_comb begin
        case (bus.difficulty)
            2'b00:   reload_val = IW'(SPAWN_EASY);
            2'b01:   reload_val = IW'(SPAWN_MED);
            default: reload_val = IW'(SPAWN_HARD);
        endcase
    end

    // The first probe of a PICK uses the live LFSR; later probes walk upward from there
    assign cand_eff  = (probe_reg == 3'd0) ? lfsr_reg[2:0] : cand_reg;
    assign hole_busy = bus.omole[cand_eff];
    assign tick_wrap = (presc_reg == PW'(TICK_DIV - 1));

    for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
        assign fire_onehot[gi] = (cand_reg == 3'(gi));
    end

    always_comb begin
        state_next    = state_reg;
        presc_next    = presc_reg;
        interval_next = interval_reg;
        cand_next     = cand_reg;
        probe_next    = probe_reg;
        mole_next     = 8'h00;
        moletime_next = moletime_reg;
        count_next    = count_reg;

        if (!bus.enable) begin
            // Also swallows a FIRE that coincides with enable dropping
            state_next    = IDLE;
            presc_next    = '0;
            interval_next = '0;
            probe_next    = 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next    = WAIT;
                    presc_next    = '0;
                    interval_next = reload_val;
                    probe_next    = 3'd0;
                    count_next    = 8'h00;
                end

                WAIT: begin
                    if (tick_wrap) begin
                        presc_next    = '0;
                        interval_next = interval_reg - IW'(1);
                        if (interval_reg <= IW'(1)) begin
                            state_next = PICK;
                            probe_next = 3'd0;
                        end
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                end

                PICK: begin
                    if (!hole_busy) begin
                        state_next = FIRE;
                        cand_next  = cand_eff;
                    end else if (probe_reg == 3'd7) begin
                        // Every hole occupied: skip this spawn and start a fresh interval
                        state_next    = WAIT;
                        presc_next    = '0;
                        interval_next = reload_val;
                        probe_next    = 3'd0;
                        cand_next     = cand_eff + 3'd1;
                    end else begin
                        cand_next  = cand_eff + 3'd1;
                        probe_next = probe_reg + 3'd1;
                    end
                end

                FIRE: begin
                    mole_next     = fire_onehot;
                    moletime_next = lfsr_reg[5:3];
                    count_next    = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
                    state_next    = WAIT;
                    presc_next    = '0;
                    interval_next = reload_val;
                    probe_next    = 3'd0;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            lfsr_reg     <= LFSR_SEED;
            presc_reg    <= '0;
            interval_reg <= '0;
            cand_reg     <= 3'd0;
            probe_reg    <= 3'd0;
            mole_reg     <= 8'h00;
            moletime_reg <= 3'd0;
            count_reg    <= 8'h00;
        end else begin
            state_reg    <= state_next;
            lfsr_reg     <= lfsr_next;
            presc_reg    <= presc_next;
            interval_reg <= interval_next;
            cand_reg     <= cand_next;
            probe_reg    <= probe_next;
            mole_reg     <= mole_next;
            moletime_reg <= moletime_next;
            count_reg    <= count_next;
        end
    end

    assign bus.mole        = mole_reg;
    assign bus.moletime    = moletime_reg;
    assign bus.spawn_count = count_reg;

endmodule
